branch_pc_sequencer: RTL and testbench
======================================

# branch_pc_sequencer

Per-thread program-counter sequencer at the Controller end of the branch path. Consumes the single resolved `jump`, `jump_destination` and `cancel` from the branch arbitration stage, which are unregistered, and registers them at its inputs. Holds one PC per hardware thread, selects threads round-robin, and issues the next PC for each thread. Each issued PC carries a cancel flag that tells the fetch/issue stage to annul that thread's in-flight instruction.

## Interface
Parameters:
- `PC_WIDTH`, 10, PC width in bits.
- `THREAD_COUNT`, 8, number of hardware threads; must be ≥ 2.
- `THREAD_WIDTH`, 3, thread index width; equals ceil(log2(THREAD_COUNT)).
- `START_PC`, 0, PC loaded into every thread at reset.
- `PC_MAX`, 1023, last legal PC; used only with `BRANCH_PC_BOUND_CHECK_EN`.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `jump`  in  1  resolved branch taken, for the current thread.
- `jump_destination`  in  PC_WIDTH  target PC; valid when `jump`=1.
- `cancel`  in  1  annul the current thread's in-flight instruction.
- `thread_active`  in  THREAD_COUNT  per-thread run enable.
- `pc`  out  PC_WIDTH  next PC of the issued thread.
- `pc_thread`  out  THREAD_WIDTH  thread that owns `pc`.
- `pc_valid`  out  1  `pc` is a live issue.
- `pc_cancel`  out  1  annul that thread's in-flight instruction.
- `pc_overflow`  out  1  one-cycle pulse: sequential PC wrapped.

## Operation
Internal state:
- Thread counter `t`: 0 → THREAD_COUNT-1 → 0, advances every cycle.
- PC array `pc_mem[THREAD_COUNT]`.
- Stage-1 register holding captured inputs and the captured thread index.

Capture (rising edge ending cycle k):
- Register `jump`, `jump_destination`, `cancel`, `thread_active[t_k]` and `t_k`.
- Inputs presented in cycle k always belong to thread `t_k`.

Compute (cycle k+1), for the captured thread `t_k`:
- Active and jump=1: next = `jump_destination`. The jump has priority over increment.
- Active and jump=0: next = `pc_mem[t_k]` + 1, modulo 2^PC_WIDTH (see Configuration).
- Inactive: next = `pc_mem[t_k]`; jump and cancel are ignored.

Update (rising edge ending cycle k+1):
- `pc_mem[t_k]` <= next.
- `pc` <= next.
- `pc_thread` <= `t_k`.
- `pc_valid` <= active.
- `pc_cancel` <= active & cancel.

Cancel rules:
- `cancel` is independent of `jump`. Both may be set: new target plus annul.
- Cancel without jump: PC still increments, `pc_cancel`=1.

Read/write ordering:
- A thread's write-back lands one cycle after capture.
- Its next read is THREAD_COUNT cycles after capture, so there is no read/write hazard.

## Timing
Reset (`reset_n` low, asynchronous, any time including mid-stream):
- Every `pc_mem` entry = `START_PC`; `t` = 0; stage-1 register cleared.
- `pc` = `START_PC`, `pc_thread` = 0, `pc_valid` = 0, `pc_cancel` = 0, `pc_overflow` = 0.
- Any captured-but-unwritten branch is discarded.

After `reset_n` deasserts:
- The first capture is thread 0.
- The first `pc_valid` = 1 appears after the second rising edge.

Latency and throughput:
- Input-to-output latency is 2 rising edges.
- Throughput is one thread per cycle; no stalls and no backpressure.

Thread enable:
- Toggling `thread_active` affects only captures from the next edge on.
- An inactive thread's PC is frozen; it resumes from the held value.

## Configuration
`BRANCH_PC_BOUND_CHECK_EN`, defined:
- Sequential increment from `PC_MAX` yields `START_PC`.
- `pc_overflow` pulses 1 alongside that issue.
- Jumps are not bound-checked.

`BRANCH_PC_BOUND_CHECK_EN`, undefined:
- Increment wraps naturally at 2^PC_WIDTH.
- `pc_overflow` is tied to 0.
- `PC_MAX` is unused.

## Test plan
- **Reset:** pulse `reset_n` low mid-stream with jumps pending -> all outputs at reset values; the first valid issue for each thread is `START_PC`+1.
- **Sequential run:** all threads active, no jumps, 3 rounds with THREAD_COUNT=8 -> each thread issues `START_PC`+1, +2, +3; `pc_thread` issues 0..7 in order.
- **Jump:** `jump`=1, `jump_destination`=0x155 presented while `t`=3 -> 2 edges later `pc`=0x155, `pc_thread`=3; thread 3's next issue is 0x156; other threads unaffected.
- **Cancel:** `cancel`=1 with `jump`=0 for thread 5 -> `pc_cancel`=1 on thread 5's issue and PC increments. `cancel`=1 with `jump`=1 -> `pc_cancel`=1 and `pc`=destination.
- **Inactive thread:** `thread_active[2]`=0 with `jump`=1 and `cancel`=1 during its slot -> `pc_valid`=0, `pc_cancel`=0, PC held; after re-enable, thread 2 continues at held+1.
- **Bound check:** with the macro defined, `PC_MAX`=0x3FF, thread jumped to 0x3FF -> next issue `START_PC` with `pc_overflow`=1 for one cycle. Without the macro -> 0x000 and `pc_overflow`=0.

Source files
------------

// File: rtl/branch_pc_sequencer.sv
// Per-thread round-robin PC sequencer: captures resolved branches, issues next PCs.
// Optional wrap-to-START_PC bound check enabled by BRANCH_PC_BOUND_CHECK_EN.
module branch_pc_sequencer #(
    parameter int unsigned PC_WIDTH     = 10,
    parameter int unsigned THREAD_COUNT = 8,
    parameter int unsigned THREAD_WIDTH = 3,
    parameter int unsigned START_PC     = 0,
    parameter int unsigned PC_MAX       = 1023
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    jump,
    input  logic [PC_WIDTH-1:0]     jump_destination,
    input  logic                    cancel,
    input  logic [THREAD_COUNT-1:0] thread_active,
    output logic [PC_WIDTH-1:0]     pc,
    output logic [THREAD_WIDTH-1:0] pc_thread,
    output logic                    pc_valid,
    output logic                    pc_cancel,
    output logic                    pc_overflow
);

    localparam logic [PC_WIDTH-1:0]     START  = PC_WIDTH'(START_PC);
    localparam logic [THREAD_WIDTH-1:0] LAST_T = THREAD_WIDTH'(THREAD_COUNT - 1);
`ifdef BRANCH_PC_BOUND_CHECK_EN
    localparam logic [PC_WIDTH-1:0]     PC_LAST = PC_WIDTH'(PC_MAX);
`endif

    logic [THREAD_WIDTH-1:0] t_q;
    logic [THREAD_WIDTH-1:0] t_d;

    logic                    s1_jump_q;
    logic                    s1_cancel_q;
    logic                    s1_active_q;
    logic [PC_WIDTH-1:0]     s1_dest_q;
    logic [THREAD_WIDTH-1:0] s1_thread_q;

    logic [PC_WIDTH-1:0]     pc_mem_q [THREAD_COUNT];
    logic [PC_WIDTH-1:0]     cur_pc;
    logic [PC_WIDTH-1:0]     pc_d;
    logic                    ovf_d;

    assign t_d    = (t_q == LAST_T) ? '0 : t_q + 1'b1;
    assign cur_pc = pc_mem_q[s1_thread_q];

    // Jump beats increment; an inactive thread keeps its PC untouched.
    always_comb begin
        pc_d  = cur_pc;
        ovf_d = 1'b0;
        if (s1_active_q) begin
            if (s1_jump_q) begin
                pc_d = s1_dest_q;
            end
`ifdef BRANCH_PC_BOUND_CHECK_EN
            else if (cur_pc == PC_LAST) begin
                pc_d  = START;
                ovf_d = 1'b1;
            end
`endif
            else begin
                pc_d = cur_pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            t_q         <= '0;
            s1_jump_q   <= 1'b0;
            s1_cancel_q <= 1'b0;
            s1_active_q <= 1'b0;
            s1_dest_q   <= '0;
            s1_thread_q <= '0;
            for (int i = 0; i < int'(THREAD_COUNT); i++) begin
                pc_mem_q[i] <= START;
            end
            pc          <= START;
            pc_thread   <= '0;
            pc_valid    <= 1'b0;
            pc_cancel   <= 1'b0;
            pc_overflow <= 1'b0;
        end else begin
            t_q         <= t_d;
            s1_jump_q   <= jump;
            s1_cancel_q <= cancel;
            s1_active_q <= thread_active[t_q];
            s1_dest_q   <= jump_destination;
            s1_thread_q <= t_q;
            // Next read of this slot is THREAD_COUNT cycles away, so no bypass.
            pc_mem_q[s1_thread_q] <= pc_d;
            pc          <= pc_d;
            pc_thread   <= s1_thread_q;
            pc_valid    <= s1_active_q;
            pc_cancel   <= s1_active_q & s1_cancel_q;
            pc_overflow <= ovf_d;
        end
    end

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Randomized bench for branch_pc_sequencer against a per-thread PC table model.
module tb_branch_pc_sequencer;

    localparam int PCW      = 10;
    localparam int TC       = 8;
    localparam int TW       = 3;
    localparam int START_PC = 0;
    localparam int PC_MAX   = 1023;

    logic           clock = 1'b0;
    logic           reset_n = 1'b1;
    logic           jump = 1'b0;
    logic [PCW-1:0] jump_destination = '0;
    logic           cancel = 1'b0;
    logic [TC-1:0]  thread_active = '1;
    logic [PCW-1:0] pc;
    logic [TW-1:0]  pc_thread;
    logic           pc_valid;
    logic           pc_cancel;
    logic           pc_overflow;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    typedef struct {
        int pc;
        int thr;
        int valid;
        int cncl;
        int ovf;
    } exp_t;

    exp_t expq[$];
    int   mpc[TC];
    int   mt;

    branch_pc_sequencer #(
        .PC_WIDTH    (PCW),
        .THREAD_COUNT(TC),
        .THREAD_WIDTH(TW),
        .START_PC    (START_PC),
        .PC_MAX      (PC_MAX)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .jump            (jump),
        .jump_destination(jump_destination),
        .cancel          (cancel),
        .thread_active   (thread_active),
        .pc              (pc),
        .pc_thread       (pc_thread),
        .pc_valid        (pc_valid),
        .pc_cancel       (pc_cancel),
        .pc_overflow     (pc_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_out(exp_t e);
        check("pc", 32'(pc), e.pc);
        check("thread", 32'(pc_thread), e.thr);
        check("valid", 32'(pc_valid), e.valid);
        check("cancel", 32'(pc_cancel), e.cncl);
        check("overflow", 32'(pc_overflow), e.ovf);
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.pc    = START_PC;
        e.thr   = 0;
        e.valid = 0;
        e.cncl  = 0;
        e.ovf   = 0;
        return e;
    endfunction

    // Asserts reset asynchronously mid-cycle, releases it on a falling edge.
    task automatic apply_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check_out(reset_exp());
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < TC; i++) mpc[i] = START_PC;
        mt = 0;
        expq.delete();
        expq.push_back(reset_exp());
        expq.push_back(reset_exp());
        reset_n = 1'b1;
    endtask

    task automatic step(bit j, int d, bit c, logic [TC-1:0] act);
        exp_t e;
        e = expq.pop_front();
        check_out(e);
        jump             = j;
        jump_destination = PCW'(d);
        cancel           = c;
        thread_active    = act;
        e.thr   = mt;
        e.pc    = mpc[mt];
        e.valid = 0;
        e.cncl  = 0;
        e.ovf   = 0;
        if (act[mt]) begin
            e.valid = 1;
            e.cncl  = int'(c);
            if (j) begin
                e.pc = d % (1 << PCW);
            end else begin
`ifdef BRANCH_PC_BOUND_CHECK_EN
                if (mpc[mt] == PC_MAX) begin
                    e.pc  = START_PC;
                    e.ovf = 1;
                end else
`endif
                e.pc = (mpc[mt] + 1) % (1 << PCW);
            end
        end
        mpc[mt] = e.pc;
        mt = (mt + 1) % TC;
        expq.push_back(e);
        @(negedge clock);
    endtask

    task automatic rand_step();
        int      r;
        int      d;
        bit      j;
        bit      c;
        logic [TC-1:0] act;
        r   = $urandom_range(0, 3);
        d   = (r == 0) ? 'h3FF : (r == 1) ? 'h3FE : $urandom_range(0, 1023);
        j   = ($urandom_range(0, 3) == 0);
        c   = ($urandom_range(0, 4) == 0);
        act = TC'($urandom | $urandom | $urandom);
        step(j, d, c, act);
    endtask

    initial begin
        int t;
        @(negedge clock);
        apply_reset();

        phase = "seq";
        repeat (3 * TC) step(0, 0, 0, '1);

        phase = "jump_cancel";
        for (int i = 0; i < TC; i++) begin
            t = mt;
            step((t == 2) || (t == 3) || (t == 6),
                 (t == 3) ? 'h155 : (t == 6) ? 'h2AA : 'h099,
                 (t == 2) || (t == 5) || (t == 6),
                 (t == 2) ? ~TC'(4) : '1);
        end
        repeat (2 * TC) step(0, 0, 0, '1);

        phase = "bound";
        for (int i = 0; i < TC; i++) begin
            t = mt;
            step(t == 1, 'h3FF, 0, '1);
        end
        repeat (2 * TC) step(0, 0, 0, '1);

        phase = "random";
        repeat (400) rand_step();

        phase = "reset_mid";
        step(1, 'h123, 1, '1);
        step(1, 'h321, 0, '1);
        apply_reset();
        repeat (2 * TC) step(0, 0, 0, '1);

        phase = "random2";
        repeat (150) rand_step();
        repeat (2) step(0, 0, 0, '1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
